// File: rtl/gaussian_out_streamer_if.sv
// gaussian_out_streamer_if: result-RAM read port plus valid/ready pixel stream with line/frame markers.
interface gaussian_out_streamer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 12
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_eol;
  logic              out_eof;
  modport master (
    output mem_rd_en, mem_addr, out_valid, out_data, out_eol, out_eof,
    input  mem_rd_data, out_ready
  );
  modport slave (
    input  mem_rd_en, mem_addr, out_valid, out_data, out_eol, out_eof,
    output mem_rd_data, out_ready
  );
endinterface

// File: rtl/gaussian_out_streamer.sv
// gaussian_out_streamer: reads the result RAM in raster order and streams pixels with eol/eof markers.
// Optional GAUSS_OUT_CHECKSUM_EN adds a 16-bit sum of accepted pixels on port checksum.
module gaussian_out_streamer #(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  gaussian_out_streamer_if.master bus
`ifdef GAUSS_OUT_CHECKSUM_EN
  ,
  output logic [15:0] checksum
`endif
);
  localparam int N  = IMG_W * IMG_H;
  localparam int CW = $clog2(IMG_W + 1);
  localparam int RW = $clog2(IMG_H + 1);
  localparam int NW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [NW-1:0] rd_count_q, rd_count_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic inflight_q, inflight_d, pend_eol_q, pend_eol_d, pend_eof_q, pend_eof_d;
  logic [DATA_W-1:0] dat_q [2];
  logic [DATA_W-1:0] dat_d [2];
  logic [1:0] eol_q, eol_d, eof_q, eof_d, cnt_q, cnt_d;
  logic hd_q, hd_d, done_q, done_d;
  logic issue, pop, fifo_pop, push, wr, last_col;
`ifdef GAUSS_OUT_CHECKSUM_EN
  logic [15:0] chk_q, chk_d;
  assign checksum = chk_q;
`endif
  assign busy = state_q != IDLE;
  assign done = done_q;
  always_comb begin
    issue = state_q == RUN && rd_count_q < NW'(N) && (cnt_q + {1'b0, inflight_q}) < 2'd2;
    last_col = col_q == CW'(IMG_W - 1);
    bus.mem_rd_en = issue;
    bus.mem_addr = rd_addr_q;
    // Empty FIFO with a read in flight: present the RAM output directly to save a cycle.
    bus.out_valid = cnt_q != 2'd0 || inflight_q;
    bus.out_data = cnt_q != 2'd0 ? dat_q[hd_q] : (inflight_q ? bus.mem_rd_data : '0);
    bus.out_eol = cnt_q != 2'd0 ? eol_q[hd_q] : inflight_q && pend_eol_q;
    bus.out_eof = cnt_q != 2'd0 ? eof_q[hd_q] : inflight_q && pend_eof_q;
    pop = bus.out_valid && bus.out_ready;
    fifo_pop = pop && cnt_q != 2'd0;
    push = inflight_q && !(cnt_q == 2'd0 && bus.out_ready);
    wr = hd_q ^ cnt_q[0];
    state_d = state_q;
    rd_addr_d = rd_addr_q;
    rd_count_d = rd_count_q;
    col_d = col_q;
    row_d = row_q;
    inflight_d = issue;
    pend_eol_d = issue ? last_col : pend_eol_q;
    pend_eof_d = issue ? last_col && row_q == RW'(IMG_H - 1) : pend_eof_q;
    dat_d = dat_q;
    eol_d = eol_q;
    eof_d = eof_q;
    done_d = 1'b0;
    if (push) begin
      dat_d[wr] = bus.mem_rd_data;
      eol_d[wr] = pend_eol_q;
      eof_d[wr] = pend_eof_q;
    end
    cnt_d = cnt_q + 2'(push) - 2'(fifo_pop);
    hd_d = hd_q ^ fifo_pop;
    if (issue) begin
      rd_addr_d = rd_addr_q + ADDR_W'(1);
      rd_count_d = rd_count_q + NW'(1);
      col_d = last_col ? '0 : col_q + CW'(1);
      row_d = last_col ? row_q + RW'(1) : row_q;
    end
`ifdef GAUSS_OUT_CHECKSUM_EN
    chk_d = pop ? chk_q + 16'(bus.out_data) : chk_q;
`endif
    if (state_q == IDLE && start) begin
      state_d = RUN;
      rd_addr_d = '0;
      rd_count_d = '0;
      col_d = '0;
      row_d = '0;
`ifdef GAUSS_OUT_CHECKSUM_EN
      chk_d = '0;
`endif
    end
    if (state_q == RUN && issue && rd_count_q == NW'(N - 1)) state_d = DRAIN;
    if (state_q == DRAIN && pop && bus.out_eof) begin
      state_d = IDLE;
      done_d = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rd_addr_q <= '0;
      rd_count_q <= '0;
      col_q <= '0;
      row_q <= '0;
      inflight_q <= 1'b0;
      pend_eol_q <= 1'b0;
      pend_eof_q <= 1'b0;
      dat_q <= '{default: '0};
      eol_q <= '0;
      eof_q <= '0;
      cnt_q <= '0;
      hd_q <= 1'b0;
      done_q <= 1'b0;
`ifdef GAUSS_OUT_CHECKSUM_EN
      chk_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      rd_addr_q <= rd_addr_d;
      rd_count_q <= rd_count_d;
      col_q <= col_d;
      row_q <= row_d;
      inflight_q <= inflight_d;
      pend_eol_q <= pend_eol_d;
      pend_eof_q <= pend_eof_d;
      dat_q <= dat_d;
      eol_q <= eol_d;
      eof_q <= eof_d;
      cnt_q <= cnt_d;
      hd_q <= hd_d;
      done_q <= done_d;
`ifdef GAUSS_OUT_CHECKSUM_EN
      chk_q <= chk_d;
`endif
    end
  end
endmodule
